// File: rtl/macarray_pkg.sv
// Shared encodings for the macarray job scheduler: FSM states, completion
// status codes and the {M,N,T} field layout of a job descriptor.
package macarray_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LAUNCH = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;
  localparam logic [1:0] ST_REPORT = 2'd3;

  localparam logic [1:0] CMPL_OK      = 2'b00;
  localparam logic [1:0] CMPL_TIMEOUT = 2'b01;
  localparam logic [1:0] CMPL_BADCFG  = 2'b10;
  localparam logic [1:0] CMPL_ABORTED = 2'b11;

  localparam int unsigned MNT_W = 12;
  localparam int unsigned M_MSB = 11;
  localparam int unsigned M_LSB = 8;
  localparam int unsigned N_MSB = 7;
  localparam int unsigned N_LSB = 4;
  localparam int unsigned T_MSB = 3;
  localparam int unsigned T_LSB = 0;

  // A job is launchable only if every dimension is non-zero.
  function automatic logic mnt_ok(input logic [MNT_W-1:0] mnt);
    return (mnt[M_MSB:M_LSB] != '0) && (mnt[N_MSB:N_LSB] != '0) &&
           (mnt[T_MSB:T_LSB] != '0);
  endfunction

endpackage

// File: rtl/job_fifo.sv
// Synchronous job descriptor FIFO; head entry is visible on dout while not
// empty, pointers wrap modulo DEPTH.
module job_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/macarray_job_sched.sv
// Job scheduler in front of the macarray engine: queues descriptors, launches
// one job at a time, runs a watchdog and returns one completion per job.
module macarray_job_sched
  import macarray_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ID_W  = 4,
  parameter int unsigned TO_W  = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             JOB_VALID,
  output logic             JOB_READY,
  input  logic [11:0]      JOB_MNT,
  input  logic [ID_W-1:0]  JOB_ID,
  input  logic [TO_W-1:0]  TIMEOUT_CYC,
  input  logic             ABORT,
  output logic             ENG_START,
  output logic [11:0]      ENG_MNT,
  input  logic             ENG_DONE,
  output logic             CMPL_VALID,
  input  logic             CMPL_READY,
  output logic [ID_W-1:0]  CMPL_ID,
  output logic [1:0]       CMPL_ST,
  output logic             BUSY
);
  localparam int unsigned FW = MNT_W + ID_W;
  localparam logic [TO_W-1:0] TO_ONE = TO_W'(1);

  logic [1:0]       state;
  logic [ID_W-1:0]  cur_id;
  logic [TO_W-1:0]  timer;
  logic [TO_W-1:0]  limit;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [FW-1:0]    fifo_dout;
  logic [MNT_W-1:0] head_mnt;
  logic [ID_W-1:0]  head_id;
  logic             end_job;
  logic [1:0]       end_code;

  assign fifo_push           = JOB_VALID && !fifo_full;
  assign fifo_pop            = (state == ST_IDLE) && !fifo_empty;
  assign {head_mnt, head_id} = fifo_dout;

  job_fifo #(
    .DEPTH (DEPTH),
    .W     (FW)
  ) u_job_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (fifo_push),
    .din   ({JOB_MNT, JOB_ID}),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign JOB_READY = !fifo_full;
  assign BUSY      = (state != ST_IDLE) || !fifo_empty;

  // Job termination: DONE beats ABORT beats the watchdog.
  always_comb begin
    end_job  = 1'b0;
    end_code = CMPL_OK;
    if (state == ST_LAUNCH && ABORT) begin
      end_job  = 1'b1;
      end_code = CMPL_ABORTED;
    end else if (state == ST_RUN) begin
      if (ENG_DONE) begin
        end_job  = 1'b1;
        end_code = CMPL_OK;
      end else if (ABORT) begin
        end_job  = 1'b1;
        end_code = CMPL_ABORTED;
      end else if (limit != '0 && timer == limit - TO_ONE) begin
        end_job  = 1'b1;
        end_code = CMPL_TIMEOUT;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_IDLE;
      cur_id     <= '0;
      timer      <= '0;
      limit      <= '0;
      ENG_START  <= 1'b0;
      ENG_MNT    <= '0;
      CMPL_VALID <= 1'b0;
      CMPL_ID    <= '0;
      CMPL_ST    <= '0;
    end else begin
      ENG_START <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (fifo_pop) begin
            cur_id <= head_id;
            if (mnt_ok(head_mnt)) begin
              state     <= ST_LAUNCH;
              ENG_START <= 1'b1;
              ENG_MNT   <= head_mnt;
            end else begin
              state      <= ST_REPORT;
              CMPL_VALID <= 1'b1;
              CMPL_ID    <= head_id;
              CMPL_ST    <= CMPL_BADCFG;
            end
          end
        end
        ST_LAUNCH: begin
          limit <= TIMEOUT_CYC;
          timer <= '0;
          state <= ST_RUN;
        end
        ST_RUN: begin
          if (timer != '1) timer <= timer + TO_ONE;
        end
        ST_REPORT: begin
          if (CMPL_READY) begin
            CMPL_VALID <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
      // Overrides the LAUNCH/RUN transitions above when the job ends.
      if (end_job) begin
        state      <= ST_REPORT;
        CMPL_VALID <= 1'b1;
        CMPL_ID    <= cur_id;
        CMPL_ST    <= end_code;
        ENG_MNT    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_macarray_job_sched.sv
// Bench for macarray_job_sched: directed vector table, multi-cycle corner
// sequences, and a randomized run against a job-level reference model.
module tb_macarray_job_sched;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned ID_W  = 4;
  localparam int unsigned TO_W  = 16;
  localparam int BIG = 1 << 30;

  logic            CLK = 1'b0;
  logic            RST;
  logic            JOB_VALID;
  logic            JOB_READY;
  logic [11:0]     JOB_MNT;
  logic [ID_W-1:0] JOB_ID;
  logic [TO_W-1:0] TIMEOUT_CYC;
  logic            ABORT;
  logic            ENG_START;
  logic [11:0]     ENG_MNT;
  logic            ENG_DONE;
  logic            CMPL_VALID;
  logic            CMPL_READY;
  logic [ID_W-1:0] CMPL_ID;
  logic [1:0]      CMPL_ST;
  logic            BUSY;

  macarray_job_sched #(
    .DEPTH (DEPTH),
    .ID_W  (ID_W),
    .TO_W  (TO_W)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .JOB_VALID   (JOB_VALID),
    .JOB_READY   (JOB_READY),
    .JOB_MNT     (JOB_MNT),
    .JOB_ID      (JOB_ID),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .ABORT       (ABORT),
    .ENG_START   (ENG_START),
    .ENG_MNT     (ENG_MNT),
    .ENG_DONE    (ENG_DONE),
    .CMPL_VALID  (CMPL_VALID),
    .CMPL_READY  (CMPL_READY),
    .CMPL_ID     (CMPL_ID),
    .CMPL_ST     (CMPL_ST),
    .BUSY        (BUSY)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [11:0] mnt;
    logic [3:0]  id;
    logic [15:0] to;
    int          done_rel;   // cycles after START; -1 none
    int          abort_rel;  // cycles after START (0 = launch cycle); -1 none
    bit          good;
    logic [1:0]  st;
    int          cmpl_rel;   // from START (good) or from push (bad config)
  } vec_t;

  typedef struct {
    logic [11:0] mnt;
    logic [3:0]  id;
  } job_t;

  vec_t vecs[11];

  // Random-phase reference model state
  job_t       acc_q[$];
  job_t       front;
  bit         inflight;
  bit         have;
  bit         drain;
  int         s_r, e_r, t_d, t_a, t_t, dd, aa, lim;
  logic [1:0] exp_st, hold_st;
  logic [3:0] hold_id;
  int         starts;
  int         extras;
  int         got[$];

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic bit cfg_ok(input logic [11:0] m);
    return (m[11:8] != 4'd0) && (m[7:4] != 4'd0) && (m[3:0] != 4'd0);
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_job_ready"}, JOB_READY, 1);
    check({tag, "_eng_start"}, ENG_START, 0);
    check({tag, "_eng_mnt"}, ENG_MNT, 0);
    check({tag, "_cmpl_valid"}, CMPL_VALID, 0);
    check({tag, "_cmpl_id"}, CMPL_ID, 0);
    check({tag, "_cmpl_st"}, CMPL_ST, 0);
    check({tag, "_busy"}, BUSY, 0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int c0;
    int s;
    int nst;
    bit seen;
    bit stable;
    string p;
    p = $sformatf("v%0d", idx);
    nst = 0; s = 0; seen = 0;
    // Stray engine events while idle must have no effect.
    ENG_DONE = 1; ABORT = 1;
    tick();
    ENG_DONE = 0; ABORT = 0;
    check({p, "_idle_stray"}, {CMPL_VALID, ENG_START, BUSY}, 3'b000);
    JOB_MNT = v.mnt; JOB_ID = v.id; JOB_VALID = 1; c0 = cyc;
    tick();
    JOB_VALID = 0;
    for (int n = 0; n < 200 && !seen; n++) begin
      if (CMPL_VALID) begin
        seen = 1;
      end else begin
        if (ENG_START) begin nst++; s = cyc; end
        TIMEOUT_CYC = ENG_START ? v.to : 16'($urandom);
        ENG_DONE = (nst > 0) && (cyc - s == v.done_rel);
        ABORT    = (nst > 0) && (cyc - s == v.abort_rel);
        if (nst > 0) check({p, "_eng_mnt_held"}, ENG_MNT, v.mnt);
        tick();
      end
    end
    ENG_DONE = 0; ABORT = 0;
    check({p, "_cmpl_seen"}, seen, 1);
    check({p, "_start_count"}, nst, v.good ? 1 : 0);
    if (v.good) begin
      check({p, "_start_latency"}, s - c0, 2);
      check({p, "_cmpl_latency"}, cyc - s, v.cmpl_rel);
    end else begin
      check({p, "_cmpl_latency"}, cyc - c0, v.cmpl_rel);
    end
    check({p, "_cmpl_id"}, CMPL_ID, v.id);
    check({p, "_cmpl_st"}, CMPL_ST, v.st);
    // Consumer stalls for 10 cycles; late DONE/ABORT in REPORT is ignored.
    stable = 1;
    ENG_DONE = 1; ABORT = 1; CMPL_READY = 0;
    for (int n = 0; n < 10; n++) begin
      tick();
      ENG_DONE = 0; ABORT = 0;
      if (!CMPL_VALID || CMPL_ID !== v.id || CMPL_ST !== v.st || ENG_START) stable = 0;
    end
    check({p, "_hold_stable"}, stable, 1);
    CMPL_READY = 1;
    tick();
    CMPL_READY = 0;
    check({p, "_after_handshake"}, {CMPL_VALID, ENG_START, BUSY}, 3'b000);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{12'h444, 4'd3,  16'd0,  20, -1, 1'b1, 2'b00, 21};
    vecs[1]  = '{12'h123, 4'd5,  16'd8,  -1, -1, 1'b1, 2'b01, 9};
    vecs[2]  = '{12'h777, 4'd6,  16'd0,   5,  5, 1'b1, 2'b00, 6};
    vecs[3]  = '{12'h321, 4'd7,  16'd0,  -1,  4, 1'b1, 2'b11, 5};
    vecs[4]  = '{12'h111, 4'd8,  16'd0,  -1,  0, 1'b1, 2'b11, 1};
    vecs[5]  = '{12'h2a3, 4'd1,  16'd4,   4, -1, 1'b1, 2'b00, 5};
    vecs[6]  = '{12'h5b6, 4'd2,  16'd4,  -1,  4, 1'b1, 2'b11, 5};
    vecs[7]  = '{12'h999, 4'd4,  16'd1,  -1, -1, 1'b1, 2'b01, 2};
    vecs[8]  = '{12'h404, 4'd9,  16'd0,  -1, -1, 1'b0, 2'b10, 2};
    vecs[9]  = '{12'h0ff, 4'd10, 16'd0,  -1, -1, 1'b0, 2'b10, 2};
    vecs[10] = '{12'h3c8, 4'd11, 16'd10,  3, -1, 1'b1, 2'b00, 4};

    RST = 1; JOB_VALID = 0; JOB_MNT = '0; JOB_ID = '0; TIMEOUT_CYC = '0;
    ABORT = 0; ENG_DONE = 0; CMPL_READY = 0;
    tick();
    tick();
    check_reset_outputs("reset");
    RST = 0;

    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

    // Back-to-back: five pushes against a stalled engine.
    TIMEOUT_CYC = 0; CMPL_READY = 0; starts = 0; extras = 0;
    for (int i = 0; i < 5; i++) begin
      JOB_MNT = 12'h111 * 12'(i + 1); JOB_ID = 4'(i + 1); JOB_VALID = 1;
      check($sformatf("b2b_ready_%0d", i), JOB_READY, 1);
      if (ENG_START) starts++;
      tick();
    end
    JOB_MNT = 12'h666; JOB_ID = 4'd6;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("b2b_full_%0d", i), JOB_READY, 0);
      if (ENG_START) starts++;
      tick();
    end
    JOB_VALID = 0;
    ENG_DONE = 1; CMPL_READY = 1;
    for (int n = 0; n < 200 && got.size() < 5; n++) begin
      if (ENG_START) starts++;
      if (CMPL_VALID) begin
        got.push_back(int'(CMPL_ID));
        check("b2b_st", CMPL_ST, 2'b00);
      end
      tick();
    end
    ENG_DONE = 0; CMPL_READY = 0;
    for (int n = 0; n < 10; n++) begin
      if (CMPL_VALID || ENG_START) extras++;
      tick();
    end
    check("b2b_cmpl_count", got.size(), 5);
    for (int i = 0; i < got.size(); i++) check($sformatf("b2b_order_%0d", i), got[i], i + 1);
    check("b2b_start_count", starts, 5);
    check("b2b_extras", extras, 0);
    check("b2b_busy_end", BUSY, 0);

    // Reset while a job runs and two more are queued.
    TIMEOUT_CYC = 0;
    for (int i = 0; i < 3; i++) begin
      JOB_MNT = 12'h222; JOB_ID = 4'(i + 1); JOB_VALID = 1;
      tick();
    end
    JOB_VALID = 0;
    for (int i = 0; i < 4; i++) tick();
    check("rst_mid_busy_before", BUSY, 1);
    RST = 1;
    tick();
    RST = 0;
    check_reset_outputs("rst_mid");
    extras = 0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (CMPL_VALID || ENG_START || BUSY) extras++;
    end
    check("rst_mid_quiet", extras, 0);

    // Randomized traffic against the job-level model.
    inflight = 0; have = 0;
    s_r = 0; e_r = 0; t_d = BIG; t_a = BIG; t_t = BIG; exp_st = 2'b00;
    for (int n = 0; n < 4000; n++) begin
      drain = (n >= 3000);
      if (drain && acc_q.size() == 0 && !BUSY) break;
      ENG_DONE = 0; ABORT = 0; TIMEOUT_CYC = 16'($urandom);
      if (ENG_START) begin
        check("rnd_start_not_inflight", inflight, 0);
        check("rnd_start_has_job", acc_q.size() > 0, 1);
        if (acc_q.size() > 0) check("rnd_launch_mnt", ENG_MNT, acc_q[0].mnt);
        inflight = 1; s_r = cyc;
        lim = $urandom_range(0, 12);
        dd  = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(1, 15));
        aa  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 15)) : -1;
        if (dd < 0 && aa < 0 && lim == 0) dd = $urandom_range(1, 15);
        TIMEOUT_CYC = 16'(lim);
        t_d = (dd < 0) ? BIG : s_r + dd;
        t_a = (aa < 0) ? BIG : s_r + aa;
        t_t = (lim == 0) ? BIG : s_r + lim;
        if (aa == 0) begin
          e_r = s_r; exp_st = 2'b11;
        end else if (t_d <= t_a && t_d <= t_t) begin
          e_r = t_d; exp_st = 2'b00;
        end else if (t_a <= t_t) begin
          e_r = t_a; exp_st = 2'b11;
        end else begin
          e_r = t_t; exp_st = 2'b01;
        end
      end
      if (inflight && cyc <= e_r && acc_q.size() > 0)
        check("rnd_eng_mnt_held", ENG_MNT, acc_q[0].mnt);
      if (inflight && cyc <= e_r) begin
        ENG_DONE = (cyc == t_d);
        ABORT    = (cyc == t_a);
      end
      if (inflight && cyc == e_r + 1) check("rnd_cmpl_on_time", CMPL_VALID, 1);
      CMPL_READY = ($urandom_range(0, 2) != 0);
      if (CMPL_VALID) begin
        if (!have) begin
          have = 1;
          check("rnd_cmpl_has_job", acc_q.size() > 0, 1);
          if (acc_q.size() > 0) begin
            front = acc_q[0];
            hold_id = front.id;
            if (cfg_ok(front.mnt)) begin
              hold_st = exp_st;
              check("rnd_cmpl_launched", inflight, 1);
            end else begin
              hold_st = 2'b10;
              check("rnd_badcfg_not_launched", inflight, 0);
            end
            check("rnd_cmpl_id", CMPL_ID, hold_id);
            check("rnd_cmpl_st", CMPL_ST, hold_st);
          end
        end else begin
          check("rnd_hold_id", CMPL_ID, hold_id);
          check("rnd_hold_st", CMPL_ST, hold_st);
        end
        ENG_DONE = ($urandom_range(0, 3) == 0);
        ABORT    = ($urandom_range(0, 3) == 0);
        if (CMPL_READY) begin
          if (acc_q.size() > 0) void'(acc_q.pop_front());
          have = 0; inflight = 0;
        end
      end
      JOB_VALID = !drain && ($urandom_range(0, 1) == 1);
      JOB_MNT   = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
      JOB_ID    = 4'($urandom);
      if (JOB_VALID && JOB_READY) acc_q.push_back('{JOB_MNT, JOB_ID});
      tick();
    end
    JOB_VALID = 0; ENG_DONE = 0; ABORT = 0; CMPL_READY = 0;
    check("rnd_drained", acc_q.size(), 0);
    check("rnd_busy_end", BUSY, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
